sram_bus_arbiter: RTL and testbench
===================================

# sram_bus_arbiter

Two-to-one arbiter between the IF-stage instruction port and the EX-stage data port, both sram-like (req / addr_ok / data_ok), onto one shared downstream sram-like port (toward the AXI bridge). Grants one address handshake per cycle, with data-first priority plus an anti-starvation counter. Records each accepted transaction's owner in an in-order FIFO so downstream responses (data_ok, rdata) reach the correct requester.

## Interface
- OUTSTANDING, 4: max accepted-but-unanswered transactions (FIFO depth, power of 2, ≥2)
- STARVE_LIMIT, 8: consecutive data grants while inst waits before inst is forced (1..255)

- clk  in  1  clock; all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- inst_req  in  1  instruction request; held until inst_addr_ok
- inst_wr / inst_size / inst_wstrb  in  1 / 2 / 4  write flag, size code (00 byte, 01 half, 10 word), byte strobes
- inst_addr / inst_wdata  in  32 / 32  address, write data
- inst_addr_ok  out  1  instruction address handshake
- inst_data_ok  out  1  instruction response
- inst_rdata  out  32  instruction read data
- data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata, data_addr_ok, data_data_ok, data_rdata: same as inst_* for the data port
- bus_req  out  1  downstream request
- bus_wr / bus_size / bus_wstrb / bus_addr / bus_wdata  out  1/2/4/32/32  muxed from the granted port
- bus_addr_ok  in  1  downstream address accept
- bus_data_ok  in  1  downstream response, returned in acceptance order
- bus_rdata  in  32  downstream read data
- rsp_err  out  1  sticky: bus_data_ok arrived with the FIFO empty

## Operation
- State: `owner` FIFO (1 bit per entry; 0 = inst, 1 = data), pointers wrapping mod OUTSTANDING, count 0..OUTSTANDING. Also `lock_valid` and `lock_sel`, `starve_cnt` (8 bits), `rsp_err`.
- `can_issue` = count < OUTSTANDING. No push is allowed at full, even if a pop happens in the same cycle.
- Grant selection, combinational:
  - If lock_valid: sel = lock_sel.
  - Else if data_req and inst_req: sel = inst when starve_cnt ≥ STARVE_LIMIT, otherwise data.
  - Else: sel = whichever port requests.
- bus_req = can_issue & (sel's req). bus_* fields are muxed from sel.
- sel_addr_ok = bus_req & bus_addr_ok. The other port's addr_ok is 0.
- Lock: if bus_req=1 and bus_addr_ok=0, set lock_valid=1 and lock_sel=sel, so the downstream request stays stable. Clear the lock on the cycle bus_addr_ok=1.
- Push `sel` into the FIFO when bus_req & bus_addr_ok.
- starve_cnt update, on each accepted handshake:
  - data accepted while inst_req=1: +1, saturating at 255.
  - inst accepted: reset to 0.
  - No change otherwise.
- Responses: on bus_data_ok with count>0, pop the head and route it.
  - Head=0: inst_data_ok=1.
  - Head=1: data_data_ok=1.
  - inst_rdata = data_rdata = bus_rdata unconditionally; only the data_ok qualifies them.
- Write transactions also consume a FIFO entry and receive a data_ok.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- bus_data_ok with count=0: ignored (no pointer or count change), rsp_err set to 1 until reset.
- The arbiter never drops a response. Pipeline flushes (exceptions, ertn) are handled upstream by discarding returned data.

## Timing
- Address path is fully combinational: req → bus_req; bus_addr_ok → inst/data_addr_ok, same cycle. Zero added latency.
- Response path is combinational: bus_data_ok/bus_rdata → inst/data_data_ok/rdata, same cycle.
- FIFO, lock, starve_cnt and rsp_err update at the clock edge after the handshake.
- Reset (asynchronous, resetn=0):
  - count=0, pointers=0, lock_valid=0, starve_cnt=0, rsp_err=0.
  - Hence bus_req, both addr_ok and both data_ok are 0 during and immediately after reset.
  - Reset mid-transaction discards all owner records. The downstream side is reset by the same resetn.
- Max sustained throughput: one handshake per cycle while count < OUTSTANDING.

## Test plan
- Single port: inst_req=1, addr 0x1C000000, bus_addr_ok=1 same cycle → inst_addr_ok=1 that cycle, count=1. bus_data_ok with rdata 0x02800C0C two cycles later → inst_data_ok=1, inst_rdata=0x02800C0C, count=0, data_data_ok=0.
- Contention and lock:
  - inst_req and data_req both high, bus_addr_ok=0 for 3 cycles → bus_addr stays the data address all 3 cycles.
  - data_req dropped by the bench in cycle 2 still does not switch the grant (lock holds).
  - bus_addr_ok=1 → data_addr_ok=1, then inst granted next cycle.
- Starvation: data_req and inst_req held high, bus_addr_ok=1 every cycle, STARVE_LIMIT=8 → 8 data grants, then 1 inst grant, then starve_cnt=0 and data resumes.
- Full FIFO:
  - 4 accepted reads, no data_ok → bus_req=0 with requests pending.
  - One bus_data_ok → count=3; bus_req rises the next cycle.
  - Responses route in order: inst, data, data, inst interleaving returns data_ok to the matching ports.
- Simultaneous push/pop at count=2: count stays 2, and ordering is preserved across pointer wrap (12 transactions with depth 4).
- Errors and reset:
  - bus_data_ok with count=0 → no data_ok on either port, rsp_err=1 and stays 1.
  - resetn low mid-burst (count=3, lock_valid=1) → all state cleared asynchronously, rsp_err=0, bus_req=0.

Source files
------------

// File: rtl/sram_bus_arbiter.sv
// Two-to-one sram-like arbiter: inst/data ports share one downstream port, data-first with anti-starvation.
// Zero latency on address and response paths; an in-order owner FIFO routes responses back to requesters.
module sram_bus_arbiter #(
    parameter int OUTSTANDING  = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,

    output logic        rsp_err
);

    localparam int PW = $clog2(OUTSTANDING);
    localparam logic [PW:0] FULL  = (PW+1)'(OUTSTANDING);
    localparam logic [7:0]  LIMIT = 8'(STARVE_LIMIT);

    logic [OUTSTANDING-1:0] owner_q, owner_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [PW:0]            count_q, count_d;
    logic                   lock_vld_q, lock_vld_d;
    logic                   lock_sel_q, lock_sel_d;
    logic [7:0]             starve_cnt_q, starve_cnt_d;
    logic                   rsp_err_q, rsp_err_d;

    // sel: 0 = inst, 1 = data
    logic sel;
    logic sel_req;
    logic can_issue;
    logic push;
    logic pop;
    logic head;

    always_comb begin
        sel = data_req;
        if (lock_vld_q) begin
            sel = lock_sel_q;
        end else if (data_req && inst_req) begin
            sel = (starve_cnt_q >= LIMIT) ? 1'b0 : 1'b1;
        end
    end

    assign can_issue = (count_q < FULL);
    assign sel_req   = sel ? data_req : inst_req;
    assign bus_req   = can_issue & sel_req;
    assign push      = bus_req & bus_addr_ok;

    assign bus_wr    = sel ? data_wr    : inst_wr;
    assign bus_size  = sel ? data_size  : inst_size;
    assign bus_wstrb = sel ? data_wstrb : inst_wstrb;
    assign bus_addr  = sel ? data_addr  : inst_addr;
    assign bus_wdata = sel ? data_wdata : inst_wdata;

    assign inst_addr_ok = push & ~sel;
    assign data_addr_ok = push & sel;

    assign head = owner_q[rd_ptr_q];
    assign pop  = bus_data_ok & (count_q != '0);

    assign inst_data_ok = pop & ~head;
    assign data_data_ok = pop & head;
    assign inst_rdata   = bus_rdata;
    assign data_rdata   = bus_rdata;
    assign rsp_err      = rsp_err_q;

    always_comb begin
        owner_d      = owner_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        lock_vld_d   = lock_vld_q;
        lock_sel_d   = lock_sel_q;
        starve_cnt_d = starve_cnt_q;
        rsp_err_d    = rsp_err_q | (bus_data_ok & (count_q == '0));

        if (push) begin
            owner_d[wr_ptr_q] = sel;
            wr_ptr_d          = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Hold the grant while the downstream stalls so its request stays stable.
        if (bus_req && !bus_addr_ok) begin
            lock_vld_d = 1'b1;
            lock_sel_d = sel;
        end else if (bus_addr_ok) begin
            lock_vld_d = 1'b0;
        end

        if (push) begin
            if (!sel) begin
                starve_cnt_d = 8'd0;
            end else if (inst_req && (starve_cnt_q != 8'hFF)) begin
                starve_cnt_d = starve_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            lock_vld_q   <= 1'b0;
            lock_sel_q   <= 1'b0;
            starve_cnt_q <= 8'd0;
            rsp_err_q    <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            lock_vld_q   <= lock_vld_d;
            lock_sel_q   <= lock_sel_d;
            starve_cnt_q <= starve_cnt_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: handshakes, lock, starvation, full FIFO, wrap, errors, reset.
module tb_sram_bus_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] bus_rdata;
    logic        rsp_err;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] A_I = 32'h1C00_0100;
    localparam logic [31:0] A_D = 32'h0000_1000;

    sram_bus_arbiter #(.OUTSTANDING(4), .STARVE_LIMIT(8)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
        .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'b10; inst_wstrb = 4'h0;
        inst_addr = A_I; inst_wdata = 32'h0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'b10; data_wstrb = 4'h0;
        data_addr = A_D; data_wdata = 32'h0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        idle();
        #3;
        resetn = 1'b1;
        tick();
    endtask

    logic        exp_q[$];
    logic [13:0] pat;
    logic        own;
    logic        want;

    initial begin
        resetn = 1'b0;
        idle();
        #8;
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_inst_data_ok", 32'(inst_data_ok), 32'd0);
        #4;
        resetn = 1'b1;
        tick();

        // single inst read
        inst_req = 1'b1; inst_addr = 32'h1C00_0000; bus_addr_ok = 1'b1;
        #2;
        chk("s_bus_req", 32'(bus_req), 32'd1);
        chk("s_bus_addr", bus_addr, 32'h1C00_0000);
        chk("s_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
        chk("s_data_addr_ok", 32'(data_addr_ok), 32'd0);
        tick();
        inst_req = 1'b0; bus_addr_ok = 1'b0;
        #2;
        chk("s_count1", 32'(dut.count_q), 32'd1);
        tick();
        bus_data_ok = 1'b1; bus_rdata = 32'h0280_0C0C;
        #2;
        chk("s_inst_data_ok", 32'(inst_data_ok), 32'd1);
        chk("s_inst_rdata", inst_rdata, 32'h0280_0C0C);
        chk("s_data_data_ok", 32'(data_data_ok), 32'd0);
        tick();
        bus_data_ok = 1'b0;
        #2;
        chk("s_count0", 32'(dut.count_q), 32'd0);

        // contention and lock
        tick();
        inst_req = 1'b1; inst_addr = A_I; data_req = 1'b1; data_addr = A_D; bus_addr_ok = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) data_req = 1'b0;
            #2;
            chk("l_bus_addr", bus_addr, A_D);
            chk("l_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
            tick();
        end
        data_req = 1'b1; bus_addr_ok = 1'b1;
        #2;
        chk("l_data_addr_ok", 32'(data_addr_ok), 32'd1);
        chk("l_inst_addr_ok2", 32'(inst_addr_ok), 32'd0);
        tick();
        data_req = 1'b0;
        #2;
        chk("l_next_addr", bus_addr, A_I);
        chk("l_next_inst_ok", 32'(inst_addr_ok), 32'd1);
        tick();
        inst_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h1111_2222;
        #2;
        chk("l_pop_data", 32'(data_data_ok), 32'd1);
        tick();
        #2;
        chk("l_pop_inst", 32'(inst_data_ok), 32'd1);
        tick();
        do_reset();

        // starvation
        inst_req = 1'b1; data_req = 1'b1; bus_addr_ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            want = (i != 8);
            #2;
            chk("st_data_ok", 32'(data_addr_ok), 32'(want));
            chk("st_inst_ok", 32'(inst_addr_ok), 32'(!want));
            if (i == 8) chk("st_cnt8", 32'(dut.starve_cnt_q), 32'd8);
            if (i == 9) chk("st_cnt0", 32'(dut.starve_cnt_q), 32'd0);
            tick();
            bus_data_ok = 1'b1;
        end
        idle();
        do_reset();

        // full FIFO: owners inst, data, data, inst
        pat = 14'b00_0000_0000_0110;
        for (int n = 0; n < 4; n++) begin
            own = pat[n];
            inst_req = !own; data_req = own; bus_addr_ok = 1'b1;
            #2;
            chk("f_push_ok", 32'(own ? data_addr_ok : inst_addr_ok), 32'd1);
            tick();
        end
        inst_req = 1'b1; data_req = 1'b0; bus_addr_ok = 1'b1;
        #2;
        chk("f_full_bus_req", 32'(bus_req), 32'd0);
        chk("f_full_count", 32'(dut.count_q), 32'd4);
        bus_data_ok = 1'b1;
        #1;
        chk("f_pop0_inst", 32'(inst_data_ok), 32'd1);
        chk("f_no_push_full", 32'(inst_addr_ok), 32'd0);
        tick();
        bus_data_ok = 1'b0; bus_addr_ok = 1'b0;
        #2;
        chk("f_count3", 32'(dut.count_q), 32'd3);
        chk("f_bus_req_up", 32'(bus_req), 32'd1);
        inst_req = 1'b0;
        for (int n = 1; n < 4; n++) begin
            own = pat[n];
            bus_data_ok = 1'b1;
            #1;
            chk("f_pop_inst", 32'(inst_data_ok), 32'(!own));
            chk("f_pop_data", 32'(data_data_ok), 32'(own));
            tick();
        end
        bus_data_ok = 1'b0;
        #2;
        chk("f_empty", 32'(dut.count_q), 32'd0);
        do_reset();

        // push/pop at count 2 across pointer wrap
        pat = 14'b10_1101_0011_0110;
        exp_q.delete();
        for (int n = 0; n < 16; n++) begin
            idle();
            if (n < 14) begin
                own = pat[n];
                inst_req = !own; data_req = own; bus_addr_ok = 1'b1;
            end
            if (n >= 2) begin
                bus_data_ok = 1'b1;
                bus_rdata = 32'hA500_0000 + 32'(n);
            end
            #2;
            if (n >= 2 && exp_q.size() > 0) begin
                chk("w_inst_route", 32'(inst_data_ok), 32'(!exp_q[0]));
                chk("w_data_route", 32'(data_data_ok), 32'(exp_q[0]));
                chk("w_rdata", exp_q[0] ? data_rdata : inst_rdata, 32'hA500_0000 + 32'(n));
                exp_q.pop_front();
            end
            if (n < 14) exp_q.push_back(own);
            tick();
            if (n >= 2 && n < 14) chk("w_count2", 32'(dut.count_q), 32'd2);
        end
        idle();
        #2;
        chk("w_drained", 32'(dut.count_q), 32'd0);
        do_reset();

        // response with empty FIFO
        bus_data_ok = 1'b1;
        #2;
        chk("e_inst_data_ok", 32'(inst_data_ok), 32'd0);
        chk("e_data_data_ok", 32'(data_data_ok), 32'd0);
        tick();
        bus_data_ok = 1'b0;
        #2;
        chk("e_rsp_err", 32'(rsp_err), 32'd1);
        chk("e_count", 32'(dut.count_q), 32'd0);
        tick(); tick(); tick();
        chk("e_rsp_sticky", 32'(rsp_err), 32'd1);

        // reset mid-burst with lock held
        for (int n = 0; n < 3; n++) begin
            inst_req = 1'b1; bus_addr_ok = 1'b1;
            tick();
        end
        inst_req = 1'b0; data_req = 1'b1; bus_addr_ok = 1'b0;
        tick();
        #2;
        chk("r_pre_count", 32'(dut.count_q), 32'd3);
        chk("r_pre_lock", 32'(dut.lock_vld_q), 32'd1);
        resetn = 1'b0;
        idle();
        #1;
        chk("r_count", 32'(dut.count_q), 32'd0);
        chk("r_lock", 32'(dut.lock_vld_q), 32'd0);
        chk("r_rsp_err", 32'(rsp_err), 32'd0);
        chk("r_bus_req", 32'(bus_req), 32'd0);
        chk("r_starve", 32'(dut.starve_cnt_q), 32'd0);
        tick();
        resetn = 1'b1;
        #2;
        chk("r_after_bus_req", 32'(bus_req), 32'd0);
        chk("r_after_addr_ok", 32'(inst_addr_ok | data_addr_ok), 32'd0);
        chk("r_after_data_ok", 32'(inst_data_ok | data_data_ok), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
